systolic_data_loader: RTL
=========================

Name: systolic_data_loader

Overview:
Fills the four systolic-array operand RAM banks (A0, A1, W0, W1) from a single valid/ready byte stream, then hands off to the array controller.
- Raises a one-cycle data_load_done once every bank word is written.
- Holds off further loads until the controller reports calc_done.
- It is the writer side of the operand RAMs that systolic_arr_ctrl reads.

Parameters:
DATA_W, 8, operand word width
ADDR_W, 8, bank address width
DEPTH, 256, words per bank (DEPTH <= 2**ADDR_W; DEPTH >= 2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
load_start  in  1  one-cycle pulse, begin a load (honoured in IDLE only)
in_data  in  DATA_W  stream word
in_valid  in  1  stream word valid
in_last  in  1  marks final stream word
in_ready  out  1  loader accepts word this cycle
ram_{a0,a1,w0,w1}_addr  out  ADDR_W  per-bank write address
ram_{a0,a1,w0,w1}_data  out  DATA_W  per-bank write data
ram_{a0,a1,w0,w1}_wren  out  1  per-bank write enable
data_load_done  out  1  one-cycle pulse, all banks written
calc_done  in  1  array controller finished; releases loader
load_busy  out  1  high in any state other than IDLE
load_err  out  1  one-cycle pulse, early in_last

Behaviour:
- Reset: the clock edge with rst_n=0 forces the following state; this applies mid-operation too, and the partial load is discarded.
  - State is IDLE.
  - All wren, data_load_done, load_err, in_ready and load_busy are 0.
  - All addr/data outputs are 0; bank index and word counter are 0.
- States: IDLE, LOAD, DONE, WAIT_CALC.
- IDLE:
  - in_ready=0.
  - On load_start, go to LOAD with bank=A0 and word=0.
- LOAD:
  - in_ready=1 combinationally while in LOAD.
  - A word is accepted when in_valid && in_ready.
  - An accepted word at cycle t produces, at cycle t+1 only, wren=1 for the current bank, addr=word and data=in_data. All other banks hold wren=0.
  - Counter rule: after acceptance, word increments. At word==DEPTH-1 it wraps to 0 and bank advances A0->A1->W0->W1.
  - Acceptance of word DEPTH-1 of W1 at cycle t: go to DONE. The write occurs at t+1 and data_load_done pulses at t+1, the same cycle as the final write.
  - in_last on the final word is expected. in_last missing on the final word is tolerated: no error.
  - in_last on any earlier accepted word:
    - That word is still written.
    - load_err pulses at t+1.
    - Return to IDLE; counters reset to 0 and data_load_done is not raised.
  - in_valid low: no write, counters hold. No timeout.
- DONE:
  - One cycle; data_load_done=1.
  - Go to WAIT_CALC.
- WAIT_CALC:
  - in_ready=0 and load_start is ignored.
  - On calc_done, go to IDLE.
  - calc_done arriving in DONE is latched (sticky flag) so that WAIT_CALC exits on its first cycle.
- Other calc_done cases: calc_done in IDLE or LOAD is ignored and does not set the flag. The flag clears on entry to IDLE.
- load_start while busy: ignored, no side effects.
- Total writes per successful load: exactly 4*DEPTH. Minimum load time is 4*DEPTH cycles with continuous in_valid; DONE follows.
- Addresses never exceed DEPTH-1. Counter widths are sized with $clog2(DEPTH), and addr is zero-extended to ADDR_W.

Decomposition:
- Shared package (systolic_pkg):
  - loader_state_t enum {IDLE, LOAD, DONE, WAIT_CALC}.
  - bank_sel_t enum {BANK_A0, BANK_A1, BANK_W0, BANK_W1}.
  - Constants OPERAND_DEPTH and OPERAND_ADDR_W.
  - systolic_arr_ctrl imports the same constants.
- One sub-module, loader_addr_gen: word/bank counters, wrap and final-word detection. It has inputs adv and clr, and outputs word, bank and is_final.
- Write-register stage and FSM stay in the top.

Test Plan:
- Reset then load_start, 1024 words with values i[7:0], continuous valid, in_last on word 1023:
  - Writes occur at a0 addr 0..255, then a1, w0, w1, with data equal to the stream value.
  - data_load_done is a single pulse in the cycle of the w1 addr 255 write.
  - in_ready then drops.
- Same load with in_valid toggling randomly at 50%:
  - Identical write contents and order.
  - No wren during cycles where in_valid was low one cycle earlier.
- in_last on word 300 (a1 addr 44):
  - a1 addr 44 is written and load_err pulses.
  - State returns to IDLE with no data_load_done.
  - A following full load starts again at a0 addr 0.
- After data_load_done, drive load_start plus valid data for 10 cycles with no calc_done:
  - in_ready stays 0, no wren, load_busy=1.
  - Pulse calc_done: load_busy=0 next cycle, and the next load_start is accepted.
- calc_done asserted coincident with the data_load_done cycle: loader returns to IDLE one cycle after WAIT_CALC entry.
- rst_n low for one cycle at a0 word 100:
  - All outputs are zero the next cycle.
  - The restarted load begins at a0 addr 0.
  - No data_load_done appears from the aborted load.

Source files
------------

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Brief    : Shared types and operand-RAM geometry for the systolic array.
// Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int OPERAND_DEPTH  = 256;
    localparam int OPERAND_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        DONE      = 2'd2,
        WAIT_CALC = 2'd3
    } loader_state_t;

    typedef enum logic [1:0] {
        BANK_A0 = 2'd0,
        BANK_A1 = 2'd1,
        BANK_W0 = 2'd2,
        BANK_W1 = 2'd3
    } bank_sel_t;

    function automatic bank_sel_t next_bank(input bank_sel_t b);
        return bank_sel_t'(b + 2'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_data_loader_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : loader_addr_gen
// Brief    : Word/bank counters for the operand loader with final-word flag.
// Revision : 1.0 - initial release
// ============================================================================
module loader_addr_gen
    import systolic_pkg::*;
#(
    parameter int DEPTH  = OPERAND_DEPTH,
    parameter int WORD_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic              clr,
    output logic [WORD_W-1:0] word,
    output bank_sel_t         bank,
    output logic              is_final
);

    localparam logic [WORD_W-1:0] c_LAST_WORD = WORD_W'(DEPTH - 1);

    logic [WORD_W-1:0] r_word;
    bank_sel_t         r_bank;
    logic              w_wrap;

    assign w_wrap = (r_word == c_LAST_WORD);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_word <= '0;
            r_bank <= BANK_A0;
        end else if (adv) begin
            if (w_wrap) begin
                r_word <= '0;
                r_bank <= next_bank(r_bank);
            end else begin
                r_word <= r_word + WORD_W'(1);
            end
        end
    end

    assign word     = r_word;
    assign bank     = r_bank;
    assign is_final = w_wrap && (r_bank == BANK_W1);

endmodule
`default_nettype wire

// File: rtl/systolic_data_loader.sv
`default_nettype none
// ============================================================================
// Module   : systolic_data_loader
// Brief    : Streams bytes into the A0/A1/W0/W1 operand banks, then waits
//            for the array controller to release it.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_data_loader
    import systolic_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = OPERAND_ADDR_W,
    parameter int DEPTH  = OPERAND_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_a0_addr,
    output logic [DATA_W-1:0] ram_a0_data,
    output logic              ram_a0_wren,
    output logic [ADDR_W-1:0] ram_a1_addr,
    output logic [DATA_W-1:0] ram_a1_data,
    output logic              ram_a1_wren,
    output logic [ADDR_W-1:0] ram_w0_addr,
    output logic [DATA_W-1:0] ram_w0_data,
    output logic              ram_w0_wren,
    output logic [ADDR_W-1:0] ram_w1_addr,
    output logic [DATA_W-1:0] ram_w1_data,
    output logic              ram_w1_wren,
    output logic              data_load_done,
    input  logic              calc_done,
    output logic              load_busy,
    output logic              load_err
);

    localparam int c_WORD_W = $clog2(DEPTH);
    localparam int c_BANKS  = 4;

    loader_state_t       r_state;
    loader_state_t       w_next;
    logic                r_calc_flag;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr [c_BANKS];
    logic [DATA_W-1:0]   r_data [c_BANKS];
    logic [c_BANKS-1:0]  r_wren;

    logic [c_WORD_W-1:0] w_word;
    bank_sel_t           w_bank;
    logic                w_is_final;
    logic                w_accept;
    logic                w_early_last;
    logic                w_clr;

    assign w_accept     = (r_state == LOAD) && in_valid;
    // in_last on the very last word is expected, so only earlier ones abort
    assign w_early_last = w_accept && in_last && !w_is_final;
    assign w_clr        = (r_state == IDLE) || w_early_last;

    loader_addr_gen #(
        .DEPTH  (DEPTH),
        .WORD_W (c_WORD_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (w_accept),
        .clr      (w_clr),
        .word     (w_word),
        .bank     (w_bank),
        .is_final (w_is_final)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (load_start) w_next = LOAD;
            LOAD: begin
                if (w_accept && w_is_final) begin
                    w_next = DONE;
                end else if (w_early_last) begin
                    w_next = IDLE;
                end
            end
            DONE:      w_next = WAIT_CALC;
            WAIT_CALC: if (calc_done || r_calc_flag) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_calc_flag <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_accept && w_is_final;
            r_err   <= w_early_last;
            // calc_done seen during DONE must still release WAIT_CALC
            if (w_next == IDLE) begin
                r_calc_flag <= 1'b0;
            end else if (r_state == DONE && calc_done) begin
                r_calc_flag <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < c_BANKS; gi++) begin : g_bank
        logic w_hit;
        assign w_hit = w_accept && (w_bank == bank_sel_t'(2'(gi)));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_wren[gi] <= 1'b0;
                r_addr[gi] <= '0;
                r_data[gi] <= '0;
            end else begin
                r_wren[gi] <= w_hit;
                if (w_hit) begin
                    r_addr[gi] <= ADDR_W'(w_word);
                    r_data[gi] <= in_data;
                end
            end
        end
    end

    assign in_ready       = (r_state == LOAD);
    assign load_busy      = (r_state != IDLE);
    assign data_load_done = r_done;
    assign load_err       = r_err;

    assign ram_a0_addr = r_addr[0];
    assign ram_a0_data = r_data[0];
    assign ram_a0_wren = r_wren[0];
    assign ram_a1_addr = r_addr[1];
    assign ram_a1_data = r_data[1];
    assign ram_a1_wren = r_wren[1];
    assign ram_w0_addr = r_addr[2];
    assign ram_w0_data = r_data[2];
    assign ram_w0_wren = r_wren[2];
    assign ram_w1_addr = r_addr[3];
    assign ram_w1_data = r_data[3];
    assign ram_w1_wren = r_wren[3];

endmodule
`default_nettype wire
